// File: rtl/adder_pkg.sv
// Shared types for the 8-bit adder stage and its downstream consumers.
// Holds the adder result struct and a saturating counter helper.
package adder_pkg;

    localparam int unsigned ADDER_DATA_W = 8;

    typedef struct packed {
        logic                    carry;
        logic [ADDER_DATA_W-1:0] sum;
    } adder_result_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/adder_result_fifo_if.sv
// Valid/ready handshake bundle between the adder stage, the result FIFO and the next stage.
// master drives results in and accepts them out; slave is the FIFO side.
interface adder_result_fifo_if #(
    parameter int unsigned DATA_W = 8
);

    logic              in_valid;
    logic [DATA_W-1:0] in_sum;
    logic              in_carry;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_sum;
    logic              out_carry;
    logic              out_ready;

    modport master (
        output in_valid,
        output in_sum,
        output in_carry,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_carry,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_sum,
        input  in_carry,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_carry,
        input  out_ready
    );

endinterface

// File: rtl/adder_fifo_mem.sv
// DEPTH-entry storage for adder results: synchronous write, asynchronous read.
// The array is intentionally not reset; the FIFO top masks its outputs instead.
module adder_fifo_mem
    import adder_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  adder_result_t wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output adder_result_t rdata_o
);

    adder_result_t mem_q [DEPTH];
    adder_result_t mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/adder_result_fifo.sv
// Buffers {carry, sum} adder results in a small FIFO with valid/ready on both sides.
// Define ADDER_FIFO_STATS_EN to add saturating carry_cnt / drop_cnt statistics ports.
module adder_result_fifo
    import adder_pkg::*;
#(
    parameter int unsigned DATA_W = ADDER_DATA_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    adder_result_fifo_if.slave bus,
    output logic [CNT_W-1:0]   count,
    output logic               carry_sticky
`ifdef ADDER_FIFO_STATS_EN
    ,
    output logic [7:0]         carry_cnt,
    output logic [7:0]         drop_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sticky_q, sticky_d;
    // Stays low from reset until the first push so stale storage never reaches the outputs.
    logic             primed_q, primed_d;

    logic          full, empty, push, pop;
    adder_result_t wr_data, rd_data;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    assign bus.in_ready  = ena & ~full;
    assign bus.out_valid = ena & ~empty;

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_ready & bus.out_valid;

    assign wr_data.carry = bus.in_carry;
    assign wr_data.sum   = ADDER_DATA_W'(bus.in_sum);

    adder_fifo_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        sticky_d = sticky_q | (push & bus.in_carry);
        primed_d = primed_q | push;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

`ifdef ADDER_FIFO_STATS_EN
    logic [7:0] carry_cnt_q, carry_cnt_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        carry_cnt_d = carry_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (push & bus.in_carry) begin
            carry_cnt_d = sat_inc8(carry_cnt_q);
        end
        if (ena & bus.in_valid & ~bus.in_ready) begin
            drop_cnt_d = sat_inc8(drop_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            carry_cnt_q <= carry_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign carry_cnt = carry_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sticky_q <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
            primed_q <= primed_d;
        end
    end

    assign bus.out_sum   = primed_q ? DATA_W'(rd_data.sum) : '0;
    assign bus.out_carry = primed_q & rd_data.carry;
    assign count         = count_q;
    assign carry_sticky  = sticky_q;

endmodule

// File: tb/tb_adder_result_fifo.sv
// Self-checking bench for adder_result_fifo: directed scenarios, then random traffic
// compared against a queue-based reference model.
module tb_adder_result_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic             ena;
    logic [CNT_W-1:0] count;
    logic             carry_sticky;
`ifdef ADDER_FIFO_STATS_EN
    logic [7:0]       carry_cnt;
    logic [7:0]       drop_cnt;
`endif

    adder_result_fifo_if #(.DATA_W(8)) bus ();

    adder_result_fifo #(
        .DATA_W (8),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .bus          (bus),
        .count        (count),
        .carry_sticky (carry_sticky)
`ifdef ADDER_FIFO_STATS_EN
        ,
        .carry_cnt    (carry_cnt),
        .drop_cnt     (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of {carry, sum} entries plus flags.
    logic [8:0] q[$];
    bit         m_sticky;
    bit         m_primed;
    int         m_ccnt;
    int         m_dcnt;
    bit         last_push;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check outputs at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        bit m_push;
        bit m_pop;
        @(negedge clk);
        if (rst_n) begin
            chk("in_ready", 32'(bus.in_ready), 32'(ena && q.size() != DEPTH));
            chk("out_valid", 32'(bus.out_valid), 32'(ena && q.size() != 0));
            chk("count", 32'(count), 32'(q.size()));
            chk("sticky", 32'(carry_sticky), 32'(m_sticky));
            if (q.size() != 0) begin
                chk("head", {23'd0, bus.out_carry, bus.out_sum}, {23'd0, q[0]});
            end else if (!m_primed) begin
                chk("idle_out", {23'd0, bus.out_carry, bus.out_sum}, 32'd0);
            end
`ifdef ADDER_FIFO_STATS_EN
            chk("carry_cnt", 32'(carry_cnt), 32'(m_ccnt));
            chk("drop_cnt", 32'(drop_cnt), 32'(m_dcnt));
`endif
        end
        m_push = ena && bus.in_valid && q.size() < DEPTH;
        m_pop  = ena && bus.out_ready && q.size() > 0;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            q.delete();
            m_sticky  = 0;
            m_primed  = 0;
            m_ccnt    = 0;
            m_dcnt    = 0;
            last_push = 0;
        end else begin
            if (ena && bus.in_valid && !m_push && m_dcnt < 255) m_dcnt++;
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
                q.push_back({bus.in_carry, bus.in_sum});
                m_primed = 1;
                if (bus.in_carry) begin
                    m_sticky = 1;
                    if (m_ccnt < 255) m_ccnt++;
                end
            end
            last_push = m_push;
        end
    endtask

    task automatic push_one(input logic c, input logic [7:0] s);
        bus.in_valid = 1'b1;
        bus.in_carry = c;
        bus.in_sum   = s;
        cycle();
        bus.in_valid = 1'b0;
    endtask

    logic [8:0] burst [4];

    initial begin
        burst[0] = 9'h002;
        burst[1] = 9'h010;
        burst[2] = 9'h100;
        burst[3] = 9'h0FF;
        rst_n         = 1'b0;
        ena           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sum    = 8'h00;
        bus.in_carry  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset for two clocks, then a single push.
        cycle();
        cycle();
        rst_n = 1'b1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
        push_one(1'b0, 8'h02);
        chk("s1_valid", 32'(bus.out_valid), 32'd1);
        chk("s1_sum", 32'(bus.out_sum), 32'h02);
        chk("s1_carry", 32'(bus.out_carry), 32'd0);
        chk("s1_count", 32'(count), 32'd1);
        chk("s1_sticky", 32'(carry_sticky), 32'd0);

        // Drain, then an ordered burst with overflow while stalled.
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(burst[i][8], burst[i][7:0]);
        chk("s2_count", 32'(count), 32'd4);
        chk("s2_in_ready", 32'(bus.in_ready), 32'd0);
        chk("s2_sticky", 32'(carry_sticky), 32'd1);

        // Full refusal.
        bus.in_valid = 1'b1;
        bus.in_sum   = 8'h33;
        bus.in_carry = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        bus.in_valid = 1'b0;
        chk("s3_count", 32'(count), 32'd4);
`ifdef ADDER_FIFO_STATS_EN
        chk("s3_drop", 32'(drop_cnt), 32'd3);
        chk("s3_ccnt", 32'(carry_cnt), 32'd1);
`endif
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("s2_order", {23'd0, bus.out_carry, bus.out_sum}, {23'd0, burst[i]});
            cycle();
        end
        bus.out_ready = 1'b0;
        chk("s2_empty_count", 32'(count), 32'd0);
        chk("s2_empty_valid", 32'(bus.out_valid), 32'd0);

        // Simultaneous push/pop at count=2.
        push_one(1'b0, 8'hA1);
        push_one(1'b0, 8'hA2);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_carry = 1'b0;
            bus.in_sum   = 8'hB0 + 8'(i);
            cycle();
            chk("s4_count", 32'(count), 32'd2);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("s4_head", 32'(bus.out_sum), 32'hB4);

        // Enable gating.
        ena           = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sum    = 8'h44;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("s5_in_ready", 32'(bus.in_ready), 32'd0);
            chk("s5_out_valid", 32'(bus.out_valid), 32'd0);
            chk("s5_count", 32'(count), 32'd2);
        end
        ena           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("s5_head", {23'd0, bus.out_carry, bus.out_sum}, 32'h0B4);

        // Reset mid-operation.
        push_one(1'b1, 8'h00);
        chk("s6_pre_count", 32'(count), 32'd3);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("s6_count", 32'(count), 32'd0);
        chk("s6_valid", 32'(bus.out_valid), 32'd0);
        chk("s6_sticky", 32'(carry_sticky), 32'd0);
        chk("s6_sum", 32'(bus.out_sum), 32'd0);
        push_one(1'b0, 8'h02);
        chk("s6_push_sum", 32'(bus.out_sum), 32'h02);
        chk("s6_push_count", 32'(count), 32'd1);

        // Random traffic; the producer holds its offer until accepted.
        for (int i = 0; i < 400; i++) begin
            rst_n         = ($urandom_range(0, 99) != 0);
            ena           = ($urandom_range(0, 7) != 0);
            bus.out_ready = $urandom_range(0, 1) == 1;
            if (!(bus.in_valid && !last_push)) begin
                bus.in_valid = $urandom_range(0, 2) != 0;
                bus.in_sum   = 8'($urandom);
                bus.in_carry = $urandom_range(0, 3) == 0;
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
